// File: rtl/pad_h_border.sv
// pad_h_border: widens every row of an N x N pel block by PAD_L left and PAD_R right border pels.
// Latency: zero added; the read and the write of an action happen in the same cycle.
// Backpressure: full stalls all border and copy actions; size reads and starved-flux skipping continue.
// Option: define PAD_H_BORDER_ZERO_FILL_EN to fill borders with 0 instead of replicating the edge pel.
module pad_h_border #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 18,
  parameter int SIZE_WIDTH = 7,
  parameter int PAD_L      = 3,
  parameter int PAD_R      = 4,
  parameter int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [FLUX-1:0][DATA_WIDTH+TAG_WIDTH-1:0]  read_port_in_pel_dout,
  input  logic [FLUX-1:0]                            read_port_in_pel_empty,
  output logic [FLUX-1:0]                            read_port_in_pel_read,
  input  logic [FLUX-1:0][SIZE_WIDTH+TAG_WIDTH-1:0]  read_port_ext_size_dout,
  input  logic [FLUX-1:0]                            read_port_ext_size_empty,
  output logic [FLUX-1:0]                            read_port_ext_size_read,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]            write_port_out_pel_din,
  output logic                                       write_port_out_pel_write,
  input  logic                                       write_port_out_pel_full
);

  typedef enum logic [1:0] {IDLE, LEFT, COPY, RIGHT} state_t;

  // Per-flux context; the edge pel only exists when borders replicate it.
  typedef struct packed {
    state_t                st;
    logic [SIZE_WIDTH-1:0] size;
    logic [SIZE_WIDTH-1:0] cnt_h;
    logic [SIZE_WIDTH-1:0] cnt_v;
`ifndef PAD_H_BORDER_ZERO_FILL_EN
    logic [DATA_WIDTH-1:0] edge_pel;
`endif
  } ctx_t;

  localparam logic [SIZE_WIDTH-1:0] L_LAST = SIZE_WIDTH'((PAD_L > 0) ? PAD_L - 1 : 0);
  localparam logic [SIZE_WIDTH-1:0] R_LAST = SIZE_WIDTH'((PAD_R > 0) ? PAD_R - 1 : 0);
  localparam state_t ROW_START = (PAD_L > 0) ? LEFT : COPY;

  ctx_t                  ctx [FLUX];
  ctx_t                  cur;
  ctx_t                  nxt;
  logic [FLUX-1:0]       elig;
  logic                  act;
  logic [TAG_WIDTH-1:0]  win;
  logic                  size_rd;
  logic                  pel_rd;
  logic                  wr;
  logic                  row_end;
  logic [DATA_WIDTH-1:0] pel;
  logic [DATA_WIDTH-1:0] wdat;
  logic                  unused_tags;

  // Incoming tag bits carry no meaning here; the flux is identified by the port lane.
  assign unused_tags = ^{read_port_in_pel_dout, read_port_ext_size_dout};

  // Eligibility of each flux from its state and the FIFO flags, then lowest-index-wins pick.
  always_comb begin
    elig = '0;
    for (int i = 0; i < FLUX; i++) begin
      case (ctx[i].st)
        IDLE:    elig[i] = !read_port_ext_size_empty[i];
`ifdef PAD_H_BORDER_ZERO_FILL_EN
        LEFT:    elig[i] = !write_port_out_pel_full;
`else
        LEFT:    elig[i] = !write_port_out_pel_full && !read_port_in_pel_empty[i];
`endif
        COPY:    elig[i] = !write_port_out_pel_full && !read_port_in_pel_empty[i];
        RIGHT:   elig[i] = !write_port_out_pel_full;
        default: elig[i] = 1'b0;
      endcase
    end
    act = 1'b0;
    win = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (elig[i]) begin
        act = 1'b1;
        win = TAG_WIDTH'(i);
      end
    end
  end

  // Action of the winning flux: strobes, write data and its next context.
  always_comb begin
    cur     = ctx[win];
    nxt     = cur;
    size_rd = 1'b0;
    pel_rd  = 1'b0;
    wr      = 1'b0;
    wdat    = '0;
    row_end = 1'b0;
    pel     = read_port_in_pel_dout[win][DATA_WIDTH-1:0];
    case (cur.st)
      IDLE: begin
        size_rd   = 1'b1;
        nxt.size  = read_port_ext_size_dout[win][SIZE_WIDTH-1:0];
        nxt.cnt_h = '0;
        nxt.cnt_v = '0;
        if (nxt.size != '0) nxt.st = ROW_START;
      end
      LEFT: begin
        wr = 1'b1;
`ifndef PAD_H_BORDER_ZERO_FILL_EN
        wdat = pel;
`endif
        nxt.cnt_h = cur.cnt_h + 1'b1;
        if (cur.cnt_h == L_LAST) begin
          nxt.cnt_h = '0;
          nxt.st    = COPY;
        end
      end
      COPY: begin
        pel_rd = 1'b1;
        wr     = 1'b1;
        wdat   = pel;
`ifndef PAD_H_BORDER_ZERO_FILL_EN
        nxt.edge_pel = pel;
`endif
        nxt.cnt_h = cur.cnt_h + 1'b1;
        if (cur.cnt_h == cur.size - 1'b1) begin
          nxt.cnt_h = '0;
          if (PAD_R > 0) nxt.st = RIGHT;
          else row_end = 1'b1;
        end
      end
      RIGHT: begin
        wr = 1'b1;
`ifndef PAD_H_BORDER_ZERO_FILL_EN
        wdat = cur.edge_pel;
`endif
        nxt.cnt_h = cur.cnt_h + 1'b1;
        if (cur.cnt_h == R_LAST) begin
          nxt.cnt_h = '0;
          row_end   = 1'b1;
        end
      end
      default: nxt.st = IDLE;
    endcase
    if (row_end) begin
      if (cur.cnt_v == cur.size - 1'b1) begin
        nxt.cnt_v = '0;
        nxt.st    = IDLE;
      end else begin
        nxt.cnt_v = cur.cnt_v + 1'b1;
        nxt.st    = ROW_START;
      end
    end
  end

  // Strobes are gated by reset so nothing leaks out while the block is being cleared.
  always_comb begin
    read_port_in_pel_read    = '0;
    read_port_ext_size_read  = '0;
    write_port_out_pel_write = 1'b0;
    write_port_out_pel_din   = {win, wdat};
    if (act && !rst) begin
      read_port_in_pel_read[win]   = pel_rd;
      read_port_ext_size_read[win] = size_rd;
      write_port_out_pel_write     = wr;
    end
  end

  // Only the winning flux advances; all others hold their context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) ctx[i] <= '0;
    end else if (act) begin
      ctx[win] <= nxt;
    end
  end

endmodule
